// File: rtl/risc_ctrl_pkg.sv
// Shared opcodes, state encoding and fetch-bus codes for the RISC control unit.
package risc_ctrl_pkg;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_LDO = 3'd1;
    localparam logic [2:0] OP_LDA = 3'd2;
    localparam logic [2:0] OP_STO = 3'd3;
    localparam logic [2:0] OP_PRE = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;
    localparam logic [2:0] OP_LDM = 3'd6;
    localparam logic [2:0] OP_HLT = 3'd7;

    localparam logic [1:0] FETCH_NONE = 2'b00;
    localparam logic [1:0] FETCH_MEM  = 2'b01;
    localparam logic [1:0] FETCH_REG  = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE, S_IF, S_PC1, S_OF, S_PC2, S_LD1, S_LD2,
        S_STR, S_STW, S_RDR, S_ACC, S_LDM1, S_LDM2, S_HALT
    } state_e;

endpackage

// File: rtl/risc_ctrl_outdec.sv
// Datapath control decode from the current state and the latched opcode.
module risc_ctrl_outdec
    import risc_ctrl_pkg::*;
(
    input  state_e     state_i,
    input  logic [2:0] op_i,
    output logic       write_r_o,
    output logic       read_r_o,
    output logic       pc_en_o,
    output logic       ac_ena_o,
    output logic       ram_ena_o,
    output logic       rom_ena_o,
    output logic       ram_write_o,
    output logic       ram_read_o,
    output logic       rom_read_o,
    output logic       ad_sel_o,
    output logic [1:0] fetch_o,
    output logic       halted_o
);

    always_comb begin
        write_r_o   = 1'b0;
        read_r_o    = 1'b0;
        pc_en_o     = 1'b0;
        ac_ena_o    = 1'b0;
        ram_ena_o   = 1'b0;
        rom_ena_o   = 1'b0;
        ram_write_o = 1'b0;
        ram_read_o  = 1'b0;
        rom_read_o  = 1'b0;
        ad_sel_o    = 1'b0;
        fetch_o     = FETCH_NONE;
        halted_o    = 1'b0;
        case (state_i)
            S_IF, S_OF: begin
                rom_ena_o  = 1'b1;
                rom_read_o = 1'b1;
                fetch_o    = FETCH_MEM;
            end
            S_PC1, S_PC2: pc_en_o = 1'b1;
            S_LD1, S_LD2: begin
                write_r_o = 1'b1;
                ad_sel_o  = 1'b1;
                // LDA reads RAM; LDO (the only other opcode reaching here) reads ROM
                if (op_i == OP_LDA) begin
                    ram_ena_o  = 1'b1;
                    ram_read_o = 1'b1;
                end else begin
                    rom_ena_o  = 1'b1;
                    rom_read_o = 1'b1;
                end
            end
            S_STR, S_RDR: begin
                read_r_o = 1'b1;
                fetch_o  = FETCH_MEM;
            end
            S_STW: begin
                ram_ena_o   = 1'b1;
                ram_write_o = 1'b1;
                ad_sel_o    = 1'b1;
                fetch_o     = FETCH_REG;
            end
            S_ACC: begin
                ac_ena_o = 1'b1;
                fetch_o  = FETCH_MEM;
            end
            S_LDM1, S_LDM2: begin
                write_r_o = 1'b1;
                ac_ena_o  = 1'b1;
            end
            S_HALT:  halted_o = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/risc_ctrl_fsm.sv
// Fetch/decode/execute sequencer with opcode latch, illegal-opcode trap and retire counter.
// Optional RISC_CTRL_MEMRDY_EN: memory wait states hold until mem_rdy.
module risc_ctrl_fsm
    import risc_ctrl_pkg::*;
#(
    parameter int unsigned INS_W = 3,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [INS_W-1:0] ins,
    input  logic             mem_rdy,
    input  logic             resume,
    output logic             write_r,
    output logic             read_r,
    output logic             PC_en,
    output logic             ac_ena,
    output logic             ram_ena,
    output logic             rom_ena,
    output logic             ram_write,
    output logic             ram_read,
    output logic             rom_read,
    output logic             ad_sel,
    output logic [1:0]       fetch,
    output logic             halted,
    output logic             ill_op,
    output logic             retire,
    output logic [CNT_W-1:0] instr_cnt
);

    state_e             state_q, state_d;
    logic [INS_W-1:0]   ir_q;
    logic               ill_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               rdy;
    logic               ins_illegal;
    logic               retire_c;
    logic               unused_ir;

`ifdef RISC_CTRL_MEMRDY_EN
    assign rdy = mem_rdy;
`else
    logic unused_mem_rdy;
    assign unused_mem_rdy = mem_rdy;
    assign rdy            = 1'b1;
`endif

    assign ins_illegal = (ins >> 3) != '0;
    assign unused_ir   = ^ir_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: state_d = S_IF;
            S_IF:   if (rdy) state_d = S_PC1;
            S_PC1: begin
                if (ins_illegal) state_d = S_HALT;
                else begin
                    case (ins[2:0])
                        OP_NOP:         state_d = S_IF;
                        OP_HLT:         state_d = S_HALT;
                        OP_PRE, OP_ADD: state_d = S_RDR;
                        OP_LDM:         state_d = S_LDM1;
                        default:        state_d = S_OF;
                    endcase
                end
            end
            S_OF:   if (rdy) state_d = S_PC2;
            S_PC2:  state_d = (ir_q[2:0] == OP_STO) ? S_STR : S_LD1;
            S_LD1:  if (rdy) state_d = S_LD2;
            S_LD2:  state_d = S_IF;
            S_STR:  state_d = S_STW;
            S_STW:  if (rdy) state_d = S_IF;
            S_RDR:  state_d = S_ACC;
            S_ACC:  state_d = S_IF;
            S_LDM1: state_d = S_LDM2;
            S_LDM2: state_d = S_IF;
            S_HALT: if (resume) state_d = S_IF;
            default: state_d = S_IDLE;
        endcase
    end

    // Retire is masked by reset so an aborted instruction never reports completion.
    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            S_PC1:                retire_c = !ins_illegal && (ins[2:0] == OP_NOP || ins[2:0] == OP_HLT);
            S_LD2, S_ACC, S_LDM2: retire_c = 1'b1;
            S_STW:                retire_c = rdy;
            default:              retire_c = 1'b0;
        endcase
        retire_c = retire_c & rst;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            ill_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_PC1) ir_q <= ins;
            if (state_q == S_PC1 && ins_illegal) ill_q <= 1'b1;
            else if (state_q == S_HALT && resume) ill_q <= 1'b0;
            if (retire_c) cnt_q <= cnt_q + 1'b1;
        end
    end

    risc_ctrl_outdec u_outdec (
        .state_i     (state_q),
        .op_i        (ir_q[2:0]),
        .write_r_o   (write_r),
        .read_r_o    (read_r),
        .pc_en_o     (PC_en),
        .ac_ena_o    (ac_ena),
        .ram_ena_o   (ram_ena),
        .rom_ena_o   (rom_ena),
        .ram_write_o (ram_write),
        .ram_read_o  (ram_read),
        .rom_read_o  (rom_read),
        .ad_sel_o    (ad_sel),
        .fetch_o     (fetch),
        .halted_o    (halted)
    );

    assign ill_op    = ill_q;
    assign retire    = retire_c;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_risc_ctrl_fsm.sv
// Cycle-table bench for risc_ctrl_fsm (INS_W=4, CNT_W=2) with an expected-value queue.
module tb_risc_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, mem_rdy, resume;
    logic [3:0] ins;
    logic       write_r, read_r, PC_en, ac_ena, ram_ena, rom_ena;
    logic       ram_write, ram_read, rom_read, ad_sel, halted, ill_op, retire;
    logic [1:0] fetch;
    logic [1:0] instr_cnt;

    always #5 clk = ~clk;

    risc_ctrl_fsm #(.INS_W(4), .CNT_W(2)) dut (
        .clk(clk), .rst(rst), .ins(ins), .mem_rdy(mem_rdy), .resume(resume),
        .write_r(write_r), .read_r(read_r), .PC_en(PC_en), .ac_ena(ac_ena),
        .ram_ena(ram_ena), .rom_ena(rom_ena), .ram_write(ram_write),
        .ram_read(ram_read), .rom_read(rom_read), .ad_sel(ad_sel),
        .fetch(fetch), .halted(halted), .ill_op(ill_op), .retire(retire),
        .instr_cnt(instr_cnt)
    );

    // {wr rd pc ac re ro rw rr ror ad f1 f0 halt ill retire}
    localparam logic [14:0] O_ZERO  = 15'b000000000000000;
    localparam logic [14:0] O_IF    = 15'b000001001001000;
    localparam logic [14:0] O_PC    = 15'b001000000000000;
    localparam logic [14:0] O_LDROM = 15'b100001001100000;
    localparam logic [14:0] O_LDRAM = 15'b100010010100000;
    localparam logic [14:0] O_STR   = 15'b010000000001000;
    localparam logic [14:0] O_STW   = 15'b000010100110000;
    localparam logic [14:0] O_ACC   = 15'b000100000001000;
    localparam logic [14:0] O_LDM   = 15'b100100000000000;
    localparam logic [14:0] O_HALT  = 15'b000000000000100;
    localparam logic [14:0] IL      = 15'b000000000000010;
    localparam logic [14:0] RT      = 15'b000000000000001;

    localparam logic [3:0] NOP = 4'd0, LDO = 4'd1, LDA = 4'd2, STO = 4'd3;
    localparam logic [3:0] ADD = 4'd5, LDM = 4'd6, HLT = 4'd7, PRE = 4'd4;
    localparam logic [3:0] NZ  = 4'hB;  // illegal noise on ins outside S_PC1

    typedef struct {
        logic        r;
        logic [3:0]  i;
        logic        m;
        logic        s;
        logic [14:0] ctl;
        logic [1:0]  cnt;
    } vec_t;

    typedef struct {
        int          idx;
        logic [14:0] ctl;
        logic [1:0]  cnt;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    wire [14:0] act = {write_r, read_r, PC_en, ac_ena, ram_ena, rom_ena, ram_write,
                       ram_read, rom_read, ad_sel, fetch, halted, ill_op, retire};

    task automatic add(input logic r, input logic [3:0] i, input logic m, input logic s,
                       input logic [14:0] c, input logic [1:0] n);
        vec_t v;
        v.r = r; v.i = i; v.m = m; v.s = s; v.ctl = c; v.cnt = n;
        tbl.push_back(v);
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if (act !== e.ctl) begin
                bad++;
                $display("FAIL step%0d ctrl got=%b exp=%b", e.idx, act, e.ctl);
            end
            total++;
            if (instr_cnt !== e.cnt) begin
                bad++;
                $display("FAIL step%0d instr_cnt got=%0d exp=%0d", e.idx, instr_cnt, e.cnt);
            end
        end
    end

    initial begin
        rst = 1'b0; ins = NOP; mem_rdy = 1'b1; resume = 1'b0;

        add(0, NZ, 1, 0, O_ZERO, 0);                  // reset state
        add(1, NZ, 1, 0, O_ZERO, 0);                  // idle after release
        // five NOPs: counter wraps 1,2,3,0,1
        add(1, NZ, 1, 0, O_IF, 0);      add(1, NOP, 1, 0, O_PC | RT, 0);
        add(1, NZ, 1, 0, O_IF, 1);      add(1, NOP, 1, 0, O_PC | RT, 1);
        add(1, NZ, 1, 0, O_IF, 2);      add(1, NOP, 1, 0, O_PC | RT, 2);
        add(1, NZ, 1, 0, O_IF, 3);      add(1, NOP, 1, 0, O_PC | RT, 3);
        add(1, NZ, 1, 0, O_IF, 0);      add(1, NOP, 1, 0, O_PC | RT, 0);
        // PRE
        add(1, NZ, 1, 0, O_IF, 1);      add(1, PRE, 1, 0, O_PC, 1);
        add(1, NZ, 1, 0, O_STR, 1);     add(1, NZ, 1, 0, O_ACC | RT, 1);
        // LDM
        add(1, NZ, 1, 0, O_IF, 2);      add(1, LDM, 1, 0, O_PC, 2);
        add(1, NZ, 1, 0, O_LDM, 2);     add(1, NZ, 1, 0, O_LDM | RT, 2);
        // LDO with ins switched to STO after latch
        add(1, NZ, 1, 0, O_IF, 3);      add(1, LDO, 1, 0, O_PC, 3);
        add(1, STO, 1, 0, O_IF, 3);     add(1, STO, 1, 0, O_PC, 3);
        add(1, STO, 1, 0, O_LDROM, 3);  add(1, STO, 1, 0, O_LDROM | RT, 3);
        // STO
        add(1, NZ, 1, 0, O_IF, 0);      add(1, STO, 1, 0, O_PC, 0);
        add(1, NZ, 1, 0, O_IF, 0);      add(1, NZ, 1, 0, O_PC, 0);
        add(1, NZ, 1, 0, O_STR, 0);
`ifdef RISC_CTRL_MEMRDY_EN
        add(1, NZ, 0, 0, O_STW, 0);
`endif
        add(1, NZ, 1, 0, O_STW | RT, 0);
        // LDA with a three-cycle stall in S_LD1
        add(1, NZ, 1, 0, O_IF, 1);      add(1, LDA, 1, 0, O_PC, 1);
        add(1, NZ, 1, 0, O_IF, 1);      add(1, NZ, 1, 0, O_PC, 1);
`ifdef RISC_CTRL_MEMRDY_EN
        add(1, NZ, 0, 0, O_LDRAM, 1);   add(1, NZ, 0, 0, O_LDRAM, 1);
        add(1, NZ, 0, 0, O_LDRAM, 1);   add(1, NZ, 1, 0, O_LDRAM, 1);
        add(1, NZ, 1, 0, O_LDRAM | RT, 1);
        add(1, NZ, 0, 0, O_IF, 2);
`else
        add(1, NZ, 0, 0, O_LDRAM, 1);   add(1, NZ, 0, 0, O_LDRAM | RT, 1);
`endif
        // HLT then resume
        add(1, NZ, 1, 0, O_IF, 2);      add(1, HLT, 1, 0, O_PC | RT, 2);
        add(1, NZ, 1, 0, O_HALT, 3);    add(1, NZ, 1, 1, O_HALT, 3);
        // illegal opcode trap, resume clears flag
        add(1, NZ, 1, 0, O_IF, 3);      add(1, 4'b1001, 1, 0, O_PC, 3);
        add(1, NZ, 1, 0, O_HALT | IL, 3); add(1, NZ, 1, 0, O_HALT | IL, 3);
        add(1, NZ, 1, 1, O_HALT | IL, 3);
        // ADD, resume ignored outside S_HALT
        add(1, NZ, 1, 0, O_IF, 3);      add(1, ADD, 1, 0, O_PC, 3);
        add(1, NZ, 1, 1, O_STR, 3);     add(1, NZ, 1, 1, O_ACC | RT, 3);
        add(1, NZ, 1, 0, O_IF, 0);      add(1, NOP, 1, 0, O_PC | RT, 0);
        // STO aborted by reset in S_STW
        add(1, NZ, 1, 0, O_IF, 1);      add(1, STO, 1, 0, O_PC, 1);
        add(1, NZ, 1, 0, O_IF, 1);      add(1, NZ, 1, 0, O_PC, 1);
        add(1, NZ, 1, 0, O_STR, 1);     add(0, NZ, 1, 1, O_STW, 1);
        add(1, NZ, 1, 0, O_ZERO, 0);    add(1, NZ, 1, 0, O_IF, 0);

        repeat (2) @(posedge clk);
        for (int k = 0; k < tbl.size(); k++) begin
            exp_t e;
            @(posedge clk);
            #1;
            rst = tbl[k].r; ins = tbl[k].i; mem_rdy = tbl[k].m; resume = tbl[k].s;
            e.idx = k; e.ctl = tbl[k].ctl; e.cnt = tbl[k].cnt;
            sb.push_back(e);
        end
        @(posedge clk);
        #2;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d exp=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
